// File: rtl/cpu_retire_monitor_if.sv
// ---------------------------------------------------------------------------
// cpu_retire_monitor_if
// Bundles the retire-event input bus and the FIFO head output bus that
// connect the writeback stage, the retire monitor and its consumer.
//   wb_valid/wb_pc/wb_instr/wb_rd/wb_data : retire event from writeback
//   out_valid/out_pc/out_rd/out_data       : FIFO head toward the consumer
//   out_ready                              : consumer accepts the head
// Modports:
//   master : producer of retire events and consumer of the FIFO head
//   slave  : the retire monitor itself
// ---------------------------------------------------------------------------
interface cpu_retire_monitor_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_instr;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic [31:0] out_data;

  modport master (
    output wb_valid, wb_pc, wb_instr, wb_rd, wb_data, out_ready,
    input  out_valid, out_pc, out_rd, out_data
  );

  modport slave (
    input  wb_valid, wb_pc, wb_instr, wb_rd, wb_data, out_ready,
    output out_valid, out_pc, out_rd, out_data
  );
endinterface

// File: rtl/cpu_retire_monitor.sv
// ---------------------------------------------------------------------------
// cpu_retire_monitor
// Watches the retire stream of the cpu core, queues every accepted retire
// event in a FIFO for an in-order consumer, counts retires and active cycles,
// and detects program end (break instruction or branch-to-self).
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : retire event input and FIFO head output (see interface)
//   halted       : sticky, set the cycle after a halting retire
//   done         : sticky, halted and FIFO drained
//   overflow     : sticky, an accepted event was dropped on a full FIFO
//   retired_cnt  : retire events accepted (wraps)
//   cycle_cnt    : cycles spent in RUN or DRAIN (wraps)
//   signature    : running register-write signature
//
// Optional feature macro: RETIRE_SIGNATURE_EN
//   defined   -> signature register folds in every counted register write
//   undefined -> signature tied to zero, no register built
// ---------------------------------------------------------------------------
module cpu_retire_monitor #(
  parameter int          DEPTH       = 16,
  parameter int          HALT_REPEAT = 3,
  parameter logic [31:0] BREAK_WORD  = 32'h0000000d
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cpu_retire_monitor_if.slave   bus,
  output logic                  halted,
  output logic                  done,
  output logic                  overflow,
  output logic [31:0]           retired_cnt,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           signature
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(HALT_REPEAT + 1);
  localparam int EW = 69;  // {pc, rd, data}

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [EW-1:0] mem_q [DEPTH];
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [31:0]   last_pc_q;
  logic          halted_q, done_q, overflow_q;
  logic [31:0]   retired_cnt_q, cycle_cnt_q;

  logic          empty_s, full_s, accept_s, pop_s, push_s, drop_s, halt_s;
  logic [AW-1:0] head_idx_s;
  logic [EW-1:0] head_s;

  // Pointers carry one extra MSB so full and empty differ only in that bit.
  assign empty_s  = (wr_ptr_q == rd_ptr_q);
  assign full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign accept_s = bus.wb_valid && ((state_q == ST_IDLE) || (state_q == ST_RUN));
  assign pop_s    = !empty_s && bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_s   = accept_s && (!full_s || pop_s);
  assign drop_s   = accept_s && full_s && !pop_s;

  // When empty, present the most recently popped entry so the head outputs hold.
  assign head_idx_s = empty_s ? (rd_ptr_q[AW-1:0] - AW'(1)) : rd_ptr_q[AW-1:0];
  assign head_s     = mem_q[head_idx_s];

  assign bus.out_valid = !empty_s;
  assign bus.out_pc    = head_s[68:37];
  assign bus.out_rd    = head_s[36:32];
  assign bus.out_data  = head_s[31:0];

  // Consecutive same-pc retire count, saturating at HALT_REPEAT.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    if (accept_s) begin
      if ((rep_cnt_q != '0) && (bus.wb_pc == last_pc_q)) begin
        if (rep_cnt_q < RW'(HALT_REPEAT)) begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end else begin
          rep_cnt_d = rep_cnt_q;
        end
      end else begin
        rep_cnt_d = RW'(1);
      end
    end else begin
      rep_cnt_d = rep_cnt_q;
    end
  end

  assign halt_s = accept_s &&
                  ((bus.wb_instr == BREAK_WORD) || (rep_cnt_d >= RW'(HALT_REPEAT)));

  // Next-state logic; a halting first event goes straight to DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = halt_s ? ST_DRAIN : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= {bus.wb_pc, bus.wb_rd, bus.wb_data};
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  // FSM state, halt tracking, sticky flags and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rep_cnt_q     <= '0;
      last_pc_q     <= 32'h0;
      halted_q      <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      retired_cnt_q <= 32'h0;
      cycle_cnt_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      if (accept_s) begin
        last_pc_q     <= bus.wb_pc;
        retired_cnt_q <= retired_cnt_q + 32'd1;
      end
      if (halt_s) begin
        halted_q <= 1'b1;
      end
      if (drop_s) begin
        overflow_q <= 1'b1;
      end
      if (state_d == ST_DONE) begin
        done_q <= 1'b1;
      end
      if ((state_q == ST_RUN) || (state_q == ST_DRAIN)) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
    end
  end

  assign halted      = halted_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign retired_cnt = retired_cnt_q;
  assign cycle_cnt   = cycle_cnt_q;

`ifdef RETIRE_SIGNATURE_EN
  logic [31:0] sig_q;

  // Signature folds in every counted register write, even if the FIFO dropped it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 32'h0;
    end else if (accept_s && (bus.wb_rd != 5'd0)) begin
      sig_q <= {sig_q[30:0], sig_q[31]} ^ bus.wb_data ^ {27'b0, bus.wb_rd};
    end
  end

  assign signature = sig_q;
`else
  assign signature = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_retire_monitor.sv
// ---------------------------------------------------------------------------
// tb_cpu_retire_monitor
// Directed scenarios followed by randomized retire streams, every cycle
// compared against a queue-based reference model of the monitor.
// ---------------------------------------------------------------------------
module tb_cpu_retire_monitor;
  localparam int          DEPTH       = 16;
  localparam int          HALT_REPEAT = 3;
  localparam logic [31:0] BREAK_WORD  = 32'h0000000d;
  localparam logic [31:0] NOP         = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halted, done, overflow;
  logic [31:0] retired_cnt, cycle_cnt, signature;

  cpu_retire_monitor_if bus ();

  cpu_retire_monitor #(
    .DEPTH(DEPTH), .HALT_REPEAT(HALT_REPEAT), .BREAK_WORD(BREAK_WORD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .halted(halted), .done(done), .overflow(overflow),
    .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt), .signature(signature)
  );

  always #5 clk = ~clk;

  int errors_cnt = 0;
  int checks_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } ev_t;

  ev_t         m_q[$];
  bit          m_started, m_halted, m_done, m_ovf;
  logic [31:0] m_retired, m_cycles, m_sig, m_last_pc;
  int          m_rep;

  task automatic model_reset();
    m_q.delete();
    m_started = 0; m_halted = 0; m_done = 0; m_ovf = 0;
    m_retired = 0; m_cycles = 0; m_sig = 0; m_last_pc = 0; m_rep = 0;
  endtask

  task automatic model_update(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                              input logic [4:0] rd, input logic [31:0] data, input bit rdy);
    bit  pop;
    bit  accept;
    ev_t e;
    pop    = (m_q.size() != 0) && rdy;
    accept = v && !m_halted;
    if (m_started && !m_done) m_cycles = m_cycles + 32'd1;
    if (m_halted && !m_done && m_q.size() == 0) m_done = 1;
    if (pop) void'(m_q.pop_front());
    if (accept) begin
      m_started = 1;
      m_retired = m_retired + 32'd1;
      if (m_rep != 0 && pc == m_last_pc) m_rep++;
      else m_rep = 1;
      m_last_pc = pc;
      if (instr == BREAK_WORD || m_rep >= HALT_REPEAT) m_halted = 1;
      if (m_q.size() < DEPTH) begin
        e.pc = pc; e.rd = rd; e.data = data;
        m_q.push_back(e);
      end else begin
        m_ovf = 1;
      end
`ifdef RETIRE_SIGNATURE_EN
      if (rd != 5'd0) m_sig = {m_sig[30:0], m_sig[31]} ^ data ^ {27'b0, rd};
`endif
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid", bus.out_valid, 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check_eq("out_pc",   bus.out_pc,   m_q[0].pc);
      check_eq("out_rd",   bus.out_rd,   32'(m_q[0].rd));
      check_eq("out_data", bus.out_data, m_q[0].data);
    end
    check_eq("halted",      halted,      32'(m_halted));
    check_eq("done",        done,        32'(m_done));
    check_eq("overflow",    overflow,    32'(m_ovf));
    check_eq("retired_cnt", retired_cnt, m_retired);
    check_eq("cycle_cnt",   cycle_cnt,   m_cycles);
    check_eq("signature",   signature,   m_sig);
  endtask

  // One clock: check state at negedge, drive inputs, advance model at posedge.
  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic [4:0] rd, input logic [31:0] data, input bit rdy);
    @(negedge clk);
    check_outputs();
    bus.wb_valid  = v;
    bus.wb_pc     = pc;
    bus.wb_instr  = instr;
    bus.wb_rd     = rd;
    bus.wb_data   = data;
    bus.out_ready = rdy;
    @(posedge clk);
    model_update(v, pc, instr, rd, data, rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, NOP, 5'd0, 32'h0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_pc = 32'h0; bus.wb_instr = NOP;
    bus.wb_rd = 5'd0; bus.wb_data = 32'h0; bus.out_ready = 1'b0;
    #1;
    check_eq("rst_out_valid", bus.out_valid, 32'h0);
    check_eq("rst_out_pc",    bus.out_pc,    32'h0);
    check_eq("rst_out_rd",    bus.out_rd,    32'h0);
    check_eq("rst_out_data",  bus.out_data,  32'h0);
    check_eq("rst_halted",    halted,        32'h0);
    check_eq("rst_done",      done,          32'h0);
    check_eq("rst_overflow",  overflow,      32'h0);
    check_eq("rst_retired",   retired_cnt,   32'h0);
    check_eq("rst_cycles",    cycle_cnt,     32'h0);
    check_eq("rst_signature", signature,     32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    int          rdy_pct;
    rst_n = 1'b1;
    model_reset();

    // Four retires, consumer always ready.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(i * 4), NOP, 5'(8 + i), 32'(i + 1), 1'b1);
    idle(3);
    #1;
    check_eq("tp1_retired", retired_cnt, 32'd4);
    check_eq("tp1_overflow", overflow, 32'd0);

    // Seventeen retires with consumer stalled, then push+pop on full.
    do_reset();
    for (int i = 0; i < 17; i++)
      step(1'b1, 32'h100 + 32'(i * 4), NOP, 5'(i % 31 + 1), $urandom, 1'b0);
    #1;
    check_eq("tp2_overflow", overflow, 32'd1);
    check_eq("tp2_retired", retired_cnt, 32'd17);
    check_eq("tp2_head_pc", bus.out_pc, 32'h100);
    step(1'b1, 32'h200, NOP, 5'd5, 32'h0000abcd, 1'b1);
    #1;
    check_eq("tp2_pushpop_head", bus.out_pc, 32'h104);
    for (int i = 0; i < 18; i++) step(1'b0, 32'h0, NOP, 5'd0, 32'h0, 1'b1);

    // Branch-to-self halt.
    do_reset();
    step(1'b1, 32'h20, NOP, 5'd1, 32'h1, 1'b1);
    step(1'b1, 32'h20, NOP, 5'd1, 32'h2, 1'b1);
    #1;
    check_eq("tp3_not_yet", halted, 32'd0);
    step(1'b1, 32'h20, NOP, 5'd1, 32'h3, 1'b1);
    #1;
    check_eq("tp3_halted", halted, 32'd1);
    idle(3);

    // Interrupted repeat does not halt.
    do_reset();
    step(1'b1, 32'h20, NOP, 5'd1, 32'h1, 1'b1);
    step(1'b1, 32'h20, NOP, 5'd1, 32'h2, 1'b1);
    step(1'b1, 32'h24, NOP, 5'd1, 32'h3, 1'b1);
    step(1'b1, 32'h20, NOP, 5'd1, 32'h4, 1'b1);
    idle(2);
    #1;
    check_eq("tp3_no_halt", halted, 32'd0);

    // Break with 5 queued; later retires ignored.
    do_reset();
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h400 + 32'(i * 4), NOP, 5'(i + 3), $urandom, 1'b0);
    step(1'b1, 32'h500, BREAK_WORD, 5'd0, 32'h0, 1'b1);
    #1;
    check_eq("tp4_halted", halted, 32'd1);
    for (int i = 0; i < 12; i++)
      step(1'b1, $urandom, NOP, 5'(i + 1), $urandom, 1'b1);
    #1;
    check_eq("tp4_done", done, 32'd1);
    check_eq("tp4_retired", retired_cnt, 32'd6);

    // Signature sequence.
    do_reset();
    step(1'b1, 32'h0, NOP, 5'd1, 32'h1, 1'b1);
    step(1'b1, 32'h4, NOP, 5'd0, 32'hff, 1'b1);
    step(1'b1, 32'h8, NOP, 5'd2, 32'h10, 1'b1);
    #1;
`ifdef RETIRE_SIGNATURE_EN
    check_eq("tp5_signature", signature, 32'h00000012);
`else
    check_eq("tp5_signature", signature, 32'h00000000);
`endif

    // Randomized runs, each starting with a reset mid-operation.
    for (int run = 0; run < 8; run++) begin
      do_reset();
      rdy_pct = 15 + run * 10;
      pc_r    = 32'h1000;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 99) >= 15) pc_r = {$urandom_range(0, 255), 2'b00};
        instr_r = $urandom;
        if (instr_r == BREAK_WORD) instr_r = NOP;
        if ($urandom_range(0, 299) == 0) instr_r = BREAK_WORD;
        step($urandom_range(0, 99) < 70, pc_r, instr_r,
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             $urandom, $urandom_range(0, 99) < rdy_pct);
      end
    end

    @(negedge clk);
    check_outputs();
    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end
endmodule
